// File: rtl/speck_key_schedule.sv
// SPECK key-schedule engine: steps the key state forward or backward by a
// programmable number of rounds, one round per clock, in a single
// start/done transaction.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 request a run (sampled only in IDLE)
//   mode                  0 = forward step, 1 = inverse step (captured at start)
//   key_in / key_out      packed state: [WORD_W-1:0] = k, then l_0 .. l_{m-2} upward
//   round_in / round_out  schedule index of key_in / key_out
//   num_rounds            number of steps to perform
//   busy                  high from the cycle after acceptance through the done cycle
//   done                  one-cycle completion pulse; results held until next acceptance
//   err                   inverse run tried to step below index 0
//   subkey_valid, subkey  per-step k word stream
//
// Build option: define SPECK_KS_SUBKEY_STREAM_EN to stream each step's k word
// on subkey/subkey_valid; otherwise both ports are tied to 0.
module speck_key_schedule #(
  parameter int unsigned WORD_W    = 64,
  parameter int unsigned KEY_WORDS = 2,
  parameter int unsigned ALPHA     = 8,
  parameter int unsigned BETA      = 3,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          mode,
  input  logic [KEY_WORDS*WORD_W-1:0]   key_in,
  input  logic [CNT_W-1:0]              round_in,
  input  logic [CNT_W-1:0]              num_rounds,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [KEY_WORDS*WORD_W-1:0]   key_out,
  output logic [CNT_W-1:0]              round_out,
  output logic                          subkey_valid,
  output logic [WORD_W-1:0]             subkey
);

  localparam int unsigned LW    = KEY_WORDS - 1;
  localparam int unsigned KEY_W = KEY_WORDS * WORD_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned a);
    return (x >> a) | (x << (WORD_W - a));
  endfunction

  function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x, input int unsigned a);
    return (x << a) | (x >> (WORD_W - a));
  endfunction

  state_e                  state_q, state_d;
  logic [WORD_W-1:0]       k_q, k_d;
  logic [LW-1:0][WORD_W-1:0] l_q, l_d;
  logic [CNT_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        rem_q, rem_d;
  logic                    mode_q, mode_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [KEY_W-1:0]        key_out_q, key_out_d;
  logic [CNT_W-1:0]        round_out_q, round_out_d;
  logic                    step_c;

  // One-round datapath, both directions computed from the current state
  logic [CNT_W-1:0]          idx_m1;
  logic [WORD_W-1:0]         idx_w, idx_m1_w, l_new, k_fwd, l_last, k_inv, l_old;
  logic [LW-1:0][WORD_W-1:0] l_fwd, l_inv;

  always_comb begin
    idx_m1   = idx_q - CNT_W'(1);
    idx_w    = WORD_W'(idx_q);
    idx_m1_w = WORD_W'(idx_m1);
    l_new    = (k_q + rotr(l_q[0], ALPHA)) ^ idx_w;
    k_fwd    = rotl(k_q, BETA) ^ l_new;
    l_last   = l_q[LW-1];
    k_inv    = rotr(k_q ^ l_last, BETA);
    l_old    = rotl((l_last ^ idx_m1_w) - k_inv, ALPHA);
    l_fwd    = l_q;
    l_inv    = l_q;
    // Forward shifts the l queue down, inverse shifts it up
    for (int j = 0; j < int'(LW) - 1; j++) begin
      l_fwd[j]   = l_q[j+1];
      l_inv[j+1] = l_q[j];
    end
    l_fwd[LW-1] = l_new;
    l_inv[0]    = l_old;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    l_d         = l_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    mode_d      = mode_q;
    err_d       = err_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    key_out_d   = key_out_q;
    round_out_d = round_out_q;
    step_c      = 1'b0;

    // busy drops the cycle after the done pulse unless a new run is accepted
    if (done_q) busy_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d     = key_in[WORD_W-1:0];
          l_d     = key_in[KEY_W-1:WORD_W];
          idx_d   = round_in;
          rem_d   = num_rounds;
          mode_d  = mode;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = (num_rounds == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Inverse from index 0 would underflow: stop without stepping
        if (mode_q && (idx_q == '0)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          step_c = 1'b1;
          if (rem_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d      = 1'b1;
        key_out_d   = {l_q, k_q};
        round_out_d = idx_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (step_c) begin
      k_d   = mode_q ? k_inv : k_fwd;
      l_d   = mode_q ? l_inv : l_fwd;
      idx_d = mode_q ? idx_m1 : (idx_q + CNT_W'(1));
      rem_d = rem_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      l_q         <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      mode_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      key_out_q   <= '0;
      round_out_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      l_q         <= l_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      key_out_q   <= key_out_d;
      round_out_q <= round_out_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign key_out   = key_out_q;
  assign round_out = round_out_q;

`ifdef SPECK_KS_SUBKEY_STREAM_EN
  // Per-step k word, valid in the cycle after each step's edge
  logic              subkey_valid_q;
  logic [WORD_W-1:0] subkey_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      subkey_valid_q <= 1'b0;
      subkey_q       <= '0;
    end else begin
      subkey_valid_q <= step_c;
      if (step_c) subkey_q <= k_d;
    end
  end

  assign subkey_valid = subkey_valid_q;
  assign subkey       = subkey_q;
`else
  assign subkey_valid = 1'b0;
  assign subkey       = '0;
`endif

endmodule

// File: tb/tb_speck_key_schedule.sv
// Directed bench for speck_key_schedule (default SPECK128 parameters, m=2).
// Expected results go into a scoreboard queue when a run is launched and are
// popped and compared when done pulses; per-step subkeys use a second queue.
module tb_speck_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [127:0] key_in = '0;
  logic [7:0]   round_in = '0;
  logic [7:0]   num_rounds = '0;
  logic         busy, done, err, subkey_valid;
  logic [127:0] key_out;
  logic [7:0]   round_out;
  logic [63:0]  subkey;

  typedef struct packed {
    logic [127:0] key;
    logic [7:0]   rnd;
    logic         err;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] sk_q[$];
  int          checks = 0;
  int          failures = 0;

  speck_key_schedule dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .key_in(key_in), .round_in(round_in), .num_rounds(num_rounds),
    .busy(busy), .done(done), .err(err), .key_out(key_out),
    .round_out(round_out), .subkey_valid(subkey_valid), .subkey(subkey)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference SPECK128 steps written directly from the round equations
  function automatic logic [127:0] fwd_step(input logic [127:0] s, input logic [7:0] i);
    logic [63:0] k, l, ln, kn;
    k  = s[63:0];
    l  = s[127:64];
    ln = (k + {l[7:0], l[63:8]}) ^ {56'h0, i};
    kn = {k[60:0], k[63:61]} ^ ln;
    return {ln, kn};
  endfunction

  function automatic logic [127:0] inv_step(input logic [127:0] s, input logic [7:0] j);
    logic [63:0] k, ll, x, kp, d;
    logic [7:0]  i;
    i  = j - 8'd1;
    k  = s[63:0];
    ll = s[127:64];
    x  = k ^ ll;
    kp = {x[2:0], x[63:3]};
    d  = (ll ^ {56'h0, i}) - kp;
    return {d[55:0], d[63:56], kp};
  endfunction

  // Launch one run at a negedge, then compare against the scoreboard on done
  task automatic run(input string tag, input logic md, input logic [127:0] key,
                     input logic [7:0] rnd, input logic [7:0] n,
                     input logic [127:0] ek, input logic [7:0] er, input logic ee,
                     input int lat);
    logic [127:0] st;
    logic [7:0]   ix;
    int           steps, c, pulses, first, last;
    logic         got;
    exp_t         e;
    st = key; ix = rnd; steps = 0;
    for (int s = 0; s < int'(n); s++) begin
      if (md && ix == 8'd0) break;
      if (md) begin st = inv_step(st, ix); ix = ix - 8'd1; end
      else    begin st = fwd_step(st, ix); ix = ix + 8'd1; end
      sk_q.push_back(st[63:0]);
      steps++;
    end
    sb_q.push_back('{ek, er, ee});
    start = 1'b1; mode = md; key_in = key; round_in = rnd; num_rounds = n;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "/busy_on"}, 128'(busy), 128'(1));
    c = 0; pulses = 0; first = -1; last = -1; got = 1'b0;
    while (c < 300) begin
      if (subkey_valid) begin
        pulses++;
        if (first < 0) first = c;
        last = c;
        if (sk_q.size() != 0) chk({tag, "/subkey"}, 128'(subkey), 128'(sk_q.pop_front()));
      end
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
      c++;
    end
    chk({tag, "/latency"}, 128'(c), 128'(lat));
    e = sb_q.pop_front();
    if (got) begin
      chk({tag, "/key_out"}, key_out, e.key);
      chk({tag, "/round_out"}, 128'(round_out), 128'(e.rnd));
      chk({tag, "/err"}, 128'(err), 128'(e.err));
      chk({tag, "/busy_done"}, 128'(busy), 128'(1));
    end
`ifdef SPECK_KS_SUBKEY_STREAM_EN
    chk({tag, "/subkey_count"}, 128'(pulses), 128'(steps));
    if (pulses > 0) chk({tag, "/subkey_contig"}, 128'(last - first + 1), 128'(pulses));
`else
    chk({tag, "/subkey_quiet"}, 128'(pulses), 128'(0));
`endif
    sk_q.delete();
    @(negedge clk);
    chk({tag, "/done_clr"}, 128'({done, busy}), 128'(0));
  endtask

  localparam logic [127:0] S0 = {64'h0f0e0d0c0b0a0908, 64'h0706050403020100};
  localparam logic [127:0] KA = 128'h0123456789abcdef_fedcba9876543210;

  initial begin
    logic [127:0] s31, s2, sw;
    int           dones, busies;
    logic [7:0]   last_round;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_ctl", 128'({busy, done, err, subkey_valid}), 128'(0));
    chk("reset_data", {key_out[63:0] ^ key_out[127:64], round_out, subkey}, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed single steps and their inverses
    run("fwd_a", 1'b0, {64'h1, 64'h0}, 8'd0, 8'd1,
        {64'h0100000000000000, 64'h0100000000000000}, 8'd1, 1'b0, 2);
    run("fwd_b", 1'b0, {64'h0, 64'h1}, 8'd5, 8'd1, {64'h4, 64'hC}, 8'd6, 1'b0, 2);
    run("inv_a", 1'b1, {64'h0100000000000000, 64'h0100000000000000}, 8'd1, 8'd1,
        {64'h1, 64'h0}, 8'd0, 1'b0, 2);
    run("inv_b", 1'b1, {64'h4, 64'hC}, 8'd6, 8'd1, {64'h0, 64'h1}, 8'd5, 1'b0, 2);

    // Zero-length run passes the state through
    run("n_zero", 1'b0, KA, 8'd9, 8'd0, KA, 8'd9, 1'b0, 1);

    // SPECK128/128 round trip over 31 rounds
    s31 = S0;
    for (int i = 0; i < 31; i++) s31 = fwd_step(s31, 8'(i));
    run("trip_fwd", 1'b0, S0, 8'd0, 8'd31, s31, 8'd31, 1'b0, 32);
    run("trip_inv", 1'b1, s31, 8'd31, 8'd31, S0, 8'd0, 1'b0, 32);

    // Inverse underflow stops at index 0 with err
    s2 = fwd_step(fwd_step(S0, 8'd0), 8'd1);
    run("underflow", 1'b1, s2, 8'd2, 8'd5, S0, 8'd0, 1'b1, 4);

    // Forward index wraps without error
    sw = fwd_step(fwd_step(fwd_step(KA, 8'hFE), 8'hFF), 8'h00);
    run("idx_wrap", 1'b0, KA, 8'hFE, 8'd3, sw, 8'd1, 1'b0, 4);

    // start while busy is ignored: exactly one done
    start = 1'b1; mode = 1'b0; key_in = S0; round_in = 8'd0; num_rounds = 8'd6;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    dones = 0; last_round = '0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin dones++; last_round = round_out; end
      @(negedge clk);
    end
    chk("ignored_start/dones", 128'(dones), 128'(1));
    chk("ignored_start/round", 128'(last_round), 128'(6));

    // Asynchronous reset mid-run, with start pulsed while busy
    start = 1'b1; mode = 1'b0; key_in = KA; round_in = 8'd3; num_rounds = 8'd10;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset/ctl", 128'({busy, done, err, subkey_valid}), 128'(0));
    chk("mid_reset/key_out", key_out, 128'(0));
    chk("mid_reset/round_sub", 128'({round_out, subkey}), 128'(0));
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0; busies = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dones++;
      if (busy) busies++;
    end
    chk("mid_reset/no_rerun", 128'({dones[15:0], busies[15:0]}), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/speck_key_schedule.md
# speck_key_schedule

Parametrised SPECK key-schedule engine that steps the key state forward (encryption direction) or backward (decryption direction) by a programmable number of rounds. It runs one round per clock, in a single start/done transaction. It sits beside the round datapath and replaces fixed-width, single-step key-update blocks. It supports every SPECK word size and key-word count, and can optionally stream each intermediate round key.

## Interface
- `WORD_W`, 64, word size n in bits (16/24/32/48/64).
- `KEY_WORDS`, 2, key words m (2..4).
- `ALPHA`, 8, right-rotate amount applied to l (use 7 when `WORD_W`=16).
- `BETA`, 3, left-rotate amount applied to k (use 2 when `WORD_W`=16).
- `CNT_W`, 8, width of the round index and the step count.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request a run; sampled only in IDLE.
- `mode`  in  1  0 = forward step, 1 = inverse step; captured at start.
- `key_in`  in  KEY_WORDS*WORD_W  packed state: [WORD_W-1:0] = k, then l_0 (oldest) … l_{m-2} upward.
- `round_in`  in  CNT_W  schedule index i of `key_in`.
- `num_rounds`  in  CNT_W  number of steps to perform.
- `busy`  out  1  high from the cycle after start acceptance until done.
- `done`  out  1  one-cycle pulse; `key_out`/`round_out`/`err` are valid from this cycle and held until the next acceptance.
- `err`  out  1  the inverse run underflowed below index 0.
- `key_out`  out  KEY_WORDS*WORD_W  resulting state, same packing as `key_in`.
- `round_out`  out  CNT_W  index of `key_out`.
- `subkey_valid`  out  1  one pulse per completed step (see Configuration).
- `subkey`  out  WORD_W  k word produced by that step.

## Operation
- State registers: k, l queue [0..m-2], idx, remaining, mode, FSM IDLE/RUN/DONE.
- Forward step at index i:
  - l_new = (k + rotr(l_0, ALPHA)) mod 2^WORD_W, XOR zero-extended i.
  - k' = rotl(k, BETA) XOR l_new.
  - The queue shifts down (l_0 drops) and l_new enters at position m-2; idx becomes i+1.
- Inverse step at idx = j (j ≥ 1), with i = j-1:
  - l_last = queue[m-2].
  - k_prev = rotr(k XOR l_last, BETA).
  - l_old = rotl((l_last XOR i) − k_prev mod 2^WORD_W, ALPHA).
  - The queue shifts up (l_last drops) and l_old enters at position 0; k = k_prev; idx = i.
- All arithmetic wraps mod 2^WORD_W. i is truncated or zero-extended to WORD_W.
- FSM transitions:
  - IDLE + start: load `key_in`/`round_in`/`mode`/`num_rounds`, clear `err`. Go to RUN, or to DONE if `num_rounds`=0.
  - RUN: one step per cycle, decrement `remaining`. After the last step, go to DONE.
  - RUN with inverse mode and idx=0 before a step: perform no step, set `err`, go to DONE. The state stays at index 0.
  - DONE: pulse `done`, go to IDLE.
- `start` while not IDLE is ignored and is not queued.
- Forward idx wraps modulo 2^CNT_W; no error is raised.

## Timing
- Reset (async, any state, including mid-run): FSM=IDLE; `busy`, `done`, `err`, `subkey_valid`=0; `key_out`, `subkey`, `round_out`=0.
- `start` is accepted at edge T. `busy` is high from T+1 through the `done` cycle.
- `done` pulses in the cycle after edge T+N+1, where N=`num_rounds`. Latency is N+2 edges from start to the done cycle. With N=0, `done` appears after edge T+1.
- Back-to-back: `start` may be reasserted in the cycle after `done` (IDLE) and is accepted.
- `subkey_valid` is registered and pulses in the cycle after each step's edge, so the N pulses are contiguous.

## Configuration
- `SPECK_KS_SUBKEY_STREAM_EN` defined: `subkey_valid`/`subkey` report every step.
- Not defined: both ports are present but tied to 0, and the subkey registers are removed. All other behaviour is identical.

## Test plan
- Forward, m=2, k=0, l_0=1, i=0, N=1 -> `key_out` k=0x0100000000000000, l_0=0x0100000000000000, `round_out`=1, `done` 3 edges after start.
- Forward, k=1, l_0=0, `round_in`=5, N=1 -> k=0xC, l_0=0x4, `round_out`=6.
- Inverse of each of the above (start from the results, `round_in`=1 and 6, N=1) -> the original states, `err`=0.
- Round trip, SPECK128/128 key k=0x0706050403020100, l_0=0x0f0e0d0c0b0a0908: forward N=31, then inverse N=31 -> original key, `round_out`=0. With STREAM_EN, 31 contiguous `subkey_valid` pulses.
- Inverse with `round_in`=2, N=5 -> `err`=1, `round_out`=0, `key_out` equals the index-0 state.
- `rst_n` low mid-run at step 3, plus `start` pulsed while busy -> all outputs 0 immediately; the ignored start causes no second run.
